// File: rtl/multdiv_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_pkg
// Shared types and constants for the iterative multiply/divide unit.
//   state_t        : controller states (IDLE, MUL, DIV, DONE)
//   mode_t         : selects the single-iteration datapath operation
//   DEFAULT_WIDTH  : default operand/result width
//   INT_MIN        : most negative two's-complement value at DEFAULT_WIDTH
//   CNT_W          : iteration counter width at DEFAULT_WIDTH
// ---------------------------------------------------------------------------
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [DEFAULT_WIDTH-1:0] INT_MIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

  localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

endpackage

// File: rtl/multdiv_step.sv
// ---------------------------------------------------------------------------
// multdiv_step
// Combinational single iteration of the multiply/divide datapath.
//   i_mode : MODE_MUL = shift-add step, MODE_DIV = restoring trial subtract
//   i_acc  : 2*WIDTH accumulator
//            MUL: {partial product high half, remaining multiplier bits}
//            DIV: {partial remainder, remaining dividend / quotient bits}
//   i_opnd : multiplicand magnitude (MUL) or divisor magnitude (DIV)
//   o_acc  : accumulator after one iteration
// ---------------------------------------------------------------------------
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  mode_t              i_mode,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_trial;

  always_comb begin
    // MUL: add the multiplicand into the high half when the current
    // multiplier bit (acc LSB) is set; the carry shifts into the top.
    w_add   = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
            + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    // DIV: remainder shifted left by one with the next dividend bit,
    // minus the divisor; a clear top bit means the subtraction fits.
    w_trial = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};

    o_acc = i_acc;
    if (i_mode == MODE_MUL) begin
      o_acc = {w_add, i_acc[WIDTH-1:1]};
    end else if (!w_trial[WIDTH]) begin
      o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// ---------------------------------------------------------------------------
// multdiv_unit
// Iterative signed multiply/divide unit, one bit per clock.
//   clock          : rising-edge clock
//   reset          : asynchronous active-low reset
//   data_operandA  : multiplicand / dividend (two's complement)
//   data_operandB  : multiplier / divisor (two's complement)
//   ctrl_MULT      : start multiply (wins when both starts are high)
//   ctrl_DIV       : start divide
//   data_result    : low WIDTH bits of product, or quotient
//   data_exception : overflow or divide-by-zero, valid with data_resultRDY
//   data_resultRDY : one-cycle strobe, high while the state is DONE
//
// Handshake: a start pulse is accepted on any edge, in any state, and aborts
// whatever is in flight. Result/exception are valid in the cycle that
// data_resultRDY is high and hold until the next completion or reset.
// There is no back-pressure; the consumer must take the result on the strobe.
//
// Build option MULTDIV_EARLY_ZERO_EN: a zero operand (or a zero divisor)
// completes straight from the start edge; otherwise latency is WIDTH+1 edges.
// ---------------------------------------------------------------------------
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_neg;
  logic                 r_div0;
  logic [WIDTH-1:0]     r_result;
  logic                 r_exc;

  logic                 w_start_mul;
  logic                 w_start_div;
  logic                 w_start;
  logic                 w_busy;
  logic                 w_early;
  logic                 w_early_exc;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_step_acc;
  logic [2*WIDTH-1:0]   w_mag_ext;
  logic [2*WIDTH-1:0]   w_signed;
  logic                 w_ovf;
  logic [WIDTH-1:0]     w_fin_result;
  logic                 w_fin_exc;
  mode_t                w_mode;

  assign w_start_mul = ctrl_MULT;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;
  assign w_start     = w_start_mul | w_start_div;
  assign w_busy      = (r_state == ST_MUL) || (r_state == ST_DIV);

  // Magnitudes as unsigned WIDTH-bit values; INT_MIN maps onto itself,
  // which is the correct unsigned magnitude.
  assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_EARLY_ZERO_EN
  // A zero divisor is covered by the B==0 term for both modes and is the
  // only early case that raises the exception.
  assign w_early     = w_start & ((data_operandA == '0) | (data_operandB == '0));
  assign w_early_exc = w_start_div & (data_operandB == '0);
`else
  assign w_early     = 1'b0;
  assign w_early_exc = 1'b0;
`endif

  assign w_mode = (r_state == ST_DIV) ? MODE_DIV : MODE_MUL;

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .i_mode (w_mode),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step_acc)
  );

  // Completion: apply the sign to the full-width magnitude (product, or
  // zero-extended quotient) and flag overflow when the signed value does
  // not fit WIDTH bits, i.e. the top WIDTH+1 bits are not all equal.
  // This also covers INT_MIN / -1, whose quotient magnitude is 2^(WIDTH-1).
  always_comb begin
    w_mag_ext    = (r_state == ST_DIV) ? {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} : r_acc;
    w_signed     = r_neg ? -w_mag_ext : w_mag_ext;
    w_ovf        = ~((&w_signed[2*WIDTH-1:WIDTH-1]) | ~(|w_signed[2*WIDTH-1:WIDTH-1]));
    w_fin_result = r_div0 ? '0 : w_signed[WIDTH-1:0];
    w_fin_exc    = r_div0 | w_ovf;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: a start always wins, even mid-operation.
  always_comb begin
    w_next = r_state;
    if (w_start_mul) begin
      w_next = w_early ? ST_DONE : ST_MUL;
    end else if (w_start_div) begin
      w_next = w_early ? ST_DONE : ST_DIV;
    end else begin
      case (r_state)
        ST_MUL, ST_DIV: if (r_cnt == LAST) w_next = ST_DONE;
        ST_DONE:        w_next = ST_IDLE;
        default:        w_next = r_state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    data_resultRDY = (r_state == ST_DONE);
    data_result    = r_result;
    data_exception = r_exc;
  end

  // Datapath: edges 1..WIDTH after the start iterate, edge WIDTH+1 finalises.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_cnt  <= '0;
      r_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_div0 <= w_start_div & (data_operandB == '0);
      if (w_start_mul) begin
        r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
        r_opnd <= w_mag_a;
      end else begin
        r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
        r_opnd <= w_mag_b;
      end
      if (w_early) begin
        r_result <= '0;
        r_exc    <= w_early_exc;
      end
    end else if (w_busy) begin
      if (r_cnt == LAST) begin
        r_result <= w_fin_result;
        r_exc    <= w_fin_exc;
      end else begin
        r_acc <= w_step_acc;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
